regression_predictor: RTL and testbench

- Downstream consumer of the linear-regression core.
- Latches the fitted coefficients B0, B1 and error when the core signals completion (errDone).
- Then streams query samples x through a 2-stage pipeline computing y_hat = B0 + B1*x in signed fixed point.
- Results are buffered in a small output FIFO with valid/ready backpressure.

---
 rtl/regression_predictor.sv | 203 ++++++++++++++++++++
 tb/tb_regression_predictor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regression_predictor.sv
// Prediction stage behind the linear-regression core: y_hat = B0 + B1*x in Q(WIDTH-FRAC).FRAC, FIFO-buffered.
// Define PRED_SAT_EN to clamp results to the WIDTH-bit signed range instead of wrapping.
module regression_predictor #(
    parameter int WIDTH     = 20,
    parameter int FRAC      = 10,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coefValid,
    input  logic [WIDTH-1:0] inB0,
    input  logic [WIDTH-1:0] inB1,
    input  logic [WIDTH-1:0] inErr,
    input  logic             xValid,
    input  logic [WIDTH-1:0] xIn,
    output logic             xReady,
    output logic             yValid,
    output logic [WIDTH-1:0] yOut,
    input  logic             yReady,
    output logic [WIDTH-1:0] errOut,
    output logic             modelLoaded,
    output logic [15:0]      predCount
);

    localparam int PROD_W   = 2 * WIDTH;
    localparam int SUM_W    = WIDTH + 1 + FRAC;
    localparam int AW       = $clog2(OUT_DEPTH);
    localparam int CW       = AW + 1;
    localparam int CREDIT_W = AW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         b0_q, b0_d, b1_q, b1_d, err_q, err_d;
    logic [WIDTH-1:0]         sh_b0_q, sh_b0_d, sh_b1_q, sh_b1_d, sh_err_q, sh_err_d;
    logic                     loaded_q, loaded_d;
    logic [15:0]              pred_count_q, pred_count_d;
    logic                     xready_q, xready_d;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]         s2_y_q, s2_y_d;
    logic [WIDTH-1:0]         fifo_mem_q [OUT_DEPTH];
    logic [WIDTH-1:0]         fifo_mem_d [OUT_DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            fifo_count_q, fifo_count_d;

    logic                     accept, push, pop;
    logic signed [PROD_W-1:0] b1_ext, x_ext;
    logic signed [SUM_W-1:0]  prod_shift, b0_ext, y_sum;
    logic [WIDTH-1:0]         y_result;
    logic [CREDIT_W-1:0]      credit;

    assign accept = xready_q && xValid;
    assign push   = s2_valid_q;
    assign pop    = (fifo_count_q != '0) && yReady;

    // Active B0 is safe in stage 2: the active set only changes while the pipeline is empty.
    always_comb begin
        b1_ext     = {{WIDTH{b1_q[WIDTH-1]}}, b1_q};
        x_ext      = {{WIDTH{xIn[WIDTH-1]}}, xIn};
        prod_shift = SUM_W'(s1_prod_q >>> FRAC);
        b0_ext     = {{(SUM_W-WIDTH){b0_q[WIDTH-1]}}, b0_q};
        y_sum      = prod_shift + b0_ext;
`ifdef PRED_SAT_EN
        if (!y_sum[SUM_W-1] && (|y_sum[SUM_W-2:WIDTH-1])) begin
            y_result = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (y_sum[SUM_W-1] && !(&y_sum[SUM_W-2:WIDTH-1])) begin
            y_result = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            y_result = y_sum[WIDTH-1:0];
        end
`else
        y_result = WIDTH'(y_sum);
`endif
    end

    always_comb begin
        state_d      = state_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        err_d        = err_q;
        sh_b0_d      = sh_b0_q;
        sh_b1_d      = sh_b1_q;
        sh_err_d     = sh_err_q;
        loaded_d     = loaded_q;
        pred_count_d = push ? pred_count_q + 16'd1 : pred_count_q;

        s1_valid_d = accept;
        s1_prod_d  = accept ? b1_ext * x_ext : s1_prod_q;
        s2_valid_d = s1_valid_q;
        s2_y_d     = s1_valid_q ? y_result : s2_y_q;

        case (state_q)
            IDLE: begin
                if (coefValid) begin
                    b0_d         = inB0;
                    b1_d         = inB1;
                    err_d        = inErr;
                    loaded_d     = 1'b1;
                    pred_count_d = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (coefValid) begin
                    sh_b0_d  = inB0;
                    sh_b1_d  = inB1;
                    sh_err_d = inErr;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (coefValid) begin
                    sh_b0_d  = inB0;
                    sh_b1_d  = inB1;
                    sh_err_d = inErr;
                end
                // A set arriving on the copy cycle itself still wins over the older shadow.
                if (!s1_valid_q && !s2_valid_q) begin
                    b0_d         = coefValid ? inB0  : sh_b0_q;
                    b1_d         = coefValid ? inB1  : sh_b1_q;
                    err_d        = coefValid ? inErr : sh_err_q;
                    pred_count_d = '0;
                    state_d      = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = s2_y_q;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        // Credit counts samples still in the pipeline so a full FIFO can never be overrun.
        credit   = CREDIT_W'(fifo_count_d) + CREDIT_W'(s1_valid_d) + CREDIT_W'(s2_valid_d);
        xready_d = (state_d == RUN) && (credit < CREDIT_W'(OUT_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            b0_q         <= '0;
            b1_q         <= '0;
            err_q        <= '0;
            sh_b0_q      <= '0;
            sh_b1_q      <= '0;
            sh_err_q     <= '0;
            loaded_q     <= 1'b0;
            pred_count_q <= '0;
            xready_q     <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_prod_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_y_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            err_q        <= err_d;
            sh_b0_q      <= sh_b0_d;
            sh_b1_q      <= sh_b1_d;
            sh_err_q     <= sh_err_d;
            loaded_q     <= loaded_d;
            pred_count_q <= pred_count_d;
            xready_q     <= xready_d;
            s1_valid_q   <= s1_valid_d;
            s1_prod_q    <= s1_prod_d;
            s2_valid_q   <= s2_valid_d;
            s2_y_q       <= s2_y_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            fifo_mem_q   <= fifo_mem_d;
        end
    end

    assign xReady      = xready_q;
    assign yValid      = (fifo_count_q != '0);
    assign yOut        = fifo_mem_q[rd_ptr_q];
    assign errOut      = err_q;
    assign modelLoaded = loaded_q;
    assign predCount   = pred_count_q;

endmodule

// File: tb/tb_regression_predictor.sv
// Directed bench for regression_predictor: a vector table of single predictions plus
// hand-written sequences for backpressure, model reload while busy and mid-run reset.
module tb_regression_predictor;

    localparam int WIDTH     = 20;
    localparam int FRAC      = 10;
    localparam int OUT_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             coefValid;
    logic [WIDTH-1:0] inB0, inB1, inErr;
    logic             xValid;
    logic [WIDTH-1:0] xIn;
    logic             xReady;
    logic             yValid;
    logic [WIDTH-1:0] yOut;
    logic             yReady;
    logic [WIDTH-1:0] errOut;
    logic             modelLoaded;
    logic [15:0]      predCount;

    always #5 clk = ~clk;

    regression_predictor #(
        .WIDTH(WIDTH), .FRAC(FRAC), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .coefValid(coefValid),
        .inB0(inB0), .inB1(inB1), .inErr(inErr),
        .xValid(xValid), .xIn(xIn), .xReady(xReady),
        .yValid(yValid), .yOut(yOut), .yReady(yReady),
        .errOut(errOut), .modelLoaded(modelLoaded), .predCount(predCount)
    );

    typedef struct {
        logic [WIDTH-1:0] b0, b1, err, x, yWrap, ySat;
    } vec_t;

    vec_t vecs [7];
    int   errors = 0;
    int   checks = 0;

    int xs [8] = '{0, 1024, -1024, 2048, 100, -3, 7, -4096};
    int ys [8] = '{2048, 2560, 1536, 3072, 2098, 2046, 2051, 0};

    function automatic vec_t mkVec(input int b0, input int b1, input int err,
                                   input int x, input int yWrap, input int ySat);
        vec_t v;
        v.b0    = WIDTH'(b0);
        v.b1    = WIDTH'(b1);
        v.err   = WIDTH'(err);
        v.x     = WIDTH'(x);
        v.yWrap = WIDTH'(yWrap);
        v.ySat  = WIDTH'(ySat);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic loadModel(input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1,
                             input logic [WIDTH-1:0] err);
        coefValid = 1'b1;
        inB0      = b0;
        inB1      = b1;
        inErr     = err;
        @(negedge clk);
        coefValid = 1'b0;
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (!xReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " xReady"}, 32'(xReady), 32'd1);
    endtask

    task automatic sendX(input logic [WIDTH-1:0] x, input string name);
        waitReady(name);
        xValid = 1'b1;
        xIn    = x;
        @(negedge clk);
        xValid = 1'b0;
    endtask

    task automatic popExpect(input logic [WIDTH-1:0] expected, input string name);
        int n = 0;
        while (!yValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " yValid"}, 32'(yValid), 32'd1);
        checkOutput({name, " yOut"}, 32'(yOut), 32'(expected));
        yReady = 1'b1;
        @(negedge clk);
        yReady = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string name;
        name = $sformatf("vec%0d", idx);
        loadModel(v.b0, v.b1, v.err);
        sendX(v.x, name);
`ifdef PRED_SAT_EN
        popExpect(v.ySat, name);
`else
        popExpect(v.yWrap, name);
`endif
        checkOutput({name, " errOut"}, 32'(errOut), 32'(v.err));
        checkOutput({name, " predCount"}, 32'(predCount), 32'd1);
    endtask

    initial begin
        int  sent;
        int  got;
        logic acc;

        vecs[0] = mkVec(0, 102400, 11, 102400, 'hC4000, 'h7FFFF);
        vecs[1] = mkVec(0, 102400, 12, -102400, 'h3C000, 'h80000);
        vecs[2] = mkVec(1024, -1024, 13, 3072, 'hFF800, 'hFF800);
        vecs[3] = mkVec(-512, 1536, 14, -1, 'hFFDFE, 'hFFDFE);
        vecs[4] = mkVec(524287, 1024, 15, 1, 'h80000, 'h7FFFF);
        vecs[5] = mkVec(-524288, 1024, 16, -1, 'h7FFFF, 'h80000);
        vecs[6] = mkVec(524286, 1024, 17, 1, 'h7FFFF, 'h7FFFF);

        rst = 1'b1; coefValid = 1'b0; inB0 = '0; inB1 = '0; inErr = '0;
        xValid = 1'b0; xIn = '0; yReady = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset yValid", 32'(yValid), 32'd0);
        checkOutput("reset xReady", 32'(xReady), 32'd0);
        checkOutput("reset modelLoaded", 32'(modelLoaded), 32'd0);
        checkOutput("reset predCount", 32'(predCount), 32'd0);
        checkOutput("reset errOut", 32'(errOut), 32'd0);
        checkOutput("reset yOut", 32'(yOut), 32'd0);

        // No model yet: queries must be refused.
        rst    = 1'b0;
        xValid = 1'b1;
        xIn    = WIDTH'(4096);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("idle c%0d", c), {29'd0, xReady, yValid, modelLoaded}, 32'd0);
        end
        xValid = 1'b0;

        $display("[TB] first model load and latency");
        loadModel(WIDTH'(2048), WIDTH'(512), WIDTH'(77));
        checkOutput("load modelLoaded", 32'(modelLoaded), 32'd1);
        checkOutput("load errOut", 32'(errOut), 32'd77);
        checkOutput("load predCount", 32'(predCount), 32'd0);
        sendX(WIDTH'(4096), "lat");
        @(negedge clk);
        checkOutput("lat early yValid", 32'(yValid), 32'd0);
        @(negedge clk);
        checkOutput("lat yValid", 32'(yValid), 32'd1);
        checkOutput("lat yOut", 32'(yOut), 32'd4096);
        checkOutput("lat predCount", 32'(predCount), 32'd1);
        yReady = 1'b1;
        @(negedge clk);
        yReady = 1'b0;
        checkOutput("lat popped yValid", 32'(yValid), 32'd0);

        $display("[TB] backpressure stream");
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            xValid = (sent < 8);
            if (sent < 8) xIn = WIDTH'(xs[sent]);
            acc = xValid && xReady;
            @(negedge clk);
            if (acc) sent++;
        end
        checkOutput("bp accepted", 32'(sent), 32'd4);
        checkOutput("bp xReady", 32'(xReady), 32'd0);
        yReady = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            xValid = (sent < 8);
            if (sent < 8) xIn = WIDTH'(xs[sent]);
            acc = xValid && xReady;
            if (yValid) begin
                checkOutput($sformatf("bp out%0d", got), 32'(yOut), 32'(WIDTH'(ys[got])));
                got++;
            end
            @(negedge clk);
            if (acc) sent++;
        end
        xValid = 1'b0;
        yReady = 1'b0;
        checkOutput("bp out count", 32'(got), 32'd8);
        checkOutput("bp predCount", 32'(predCount), 32'd9);
        checkOutput("bp empty", 32'(yValid), 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] reload with samples in flight");
        loadModel(WIDTH'(2048), WIDTH'(512), WIDTH'(9));
        waitReady("drain start");
        xValid = 1'b1;
        xIn    = WIDTH'(2048);
        @(negedge clk);
        checkOutput("drain second ready", 32'(xReady), 32'd1);
        xIn = WIDTH'(4096);
        @(negedge clk);
        xValid    = 1'b0;
        coefValid = 1'b1;
        inB0      = WIDTH'(1024);
        inB1      = WIDTH'(0);
        inErr     = WIDTH'(5);
        @(negedge clk);
        coefValid = 1'b0;
        checkOutput("drain blocked 1", 32'(xReady), 32'd0);
        checkOutput("drain old err", 32'(errOut), 32'd9);
        @(negedge clk);
        checkOutput("drain blocked 2", 32'(xReady), 32'd0);
        checkOutput("drain predCount old", 32'(predCount), 32'd2);
        @(negedge clk);
        checkOutput("drain reopen", 32'(xReady), 32'd1);
        checkOutput("drain predCount reset", 32'(predCount), 32'd0);
        checkOutput("drain new err", 32'(errOut), 32'd5);
        popExpect(WIDTH'(3072), "drain oldA");
        popExpect(WIDTH'(4096), "drain oldB");
        sendX(WIDTH'(777), "drain new");
        popExpect(WIDTH'(1024), "drain new");
        checkOutput("drain new predCount", 32'(predCount), 32'd1);

        $display("[TB] reset while busy");
        loadModel(WIDTH'(0), WIDTH'(1024), WIDTH'(3));
        waitReady("rst fill");
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst fill ready%0d", i), 32'(xReady), 32'd1);
            xValid = 1'b1;
            xIn    = WIDTH'(i + 1);
            @(negedge clk);
        end
        xValid = 1'b0;
        @(negedge clk);
        checkOutput("rst pre predCount", 32'(predCount), 32'd3);
        checkOutput("rst pre yOut", 32'(yOut), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst yValid", 32'(yValid), 32'd0);
        checkOutput("rst xReady", 32'(xReady), 32'd0);
        checkOutput("rst predCount", 32'(predCount), 32'd0);
        checkOutput("rst modelLoaded", 32'(modelLoaded), 32'd0);
        checkOutput("rst errOut", 32'(errOut), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst no stale output", 32'(yValid), 32'd0);
        checkOutput("rst stays idle", 32'(xReady), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
